// File: rtl/tick_timer.sv
// tick_timer: counts rising edges of a prescaler terminal-count pulse down
// from a latched period. Supports one-shot and periodic modes, and provides
// an expiry pulse, a sticky irq flag and a sticky overrun flag.
module tick_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             irq,
    output logic             overrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_mode;
    logic             r_tick_prev;
    logic             r_busy;
    logic             r_expired;
    logic             r_irq;
    logic             r_overrun;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic             w_mode_nxt;
    logic             w_expire;
    logic             w_irq_nxt;
    logic             w_overrun_nxt;
    logic             w_tick;
    logic             w_load;

    // A held-high tick_in counts only on its first cycle.
    assign w_tick = tick_in & ~r_tick_prev;
    // A start counts only when stop is low and the period is non-zero.
    assign w_load = start & ~stop & (period != '0);

    // Next-state, counter and latched-configuration logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_period_nxt = r_period;
        w_mode_nxt   = r_mode;
        w_expire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt  = ST_RUN;
                    w_count_nxt  = period;
                    w_period_nxt = period;
                    w_mode_nxt   = mode;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else if (w_load) begin
                    // Restart overrides a same-cycle tick, so no expiry here.
                    w_count_nxt  = period;
                    w_period_nxt = period;
                    w_mode_nxt   = mode;
                end else if (w_tick) begin
                    if (r_count == ONE) begin
                        w_expire = 1'b1;
                        if (r_mode) begin
                            w_count_nxt = r_period;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = '0;
                        end
                    end else if (r_count != '0) begin
                        w_count_nxt = r_count - ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // Sticky flags: an expiry sets irq even when acknowledged in the same cycle.
    always_comb begin
        w_irq_nxt     = r_irq;
        w_overrun_nxt = r_overrun;
        if (w_expire) begin
            w_irq_nxt = 1'b1;
            if (irq_ack) begin
                w_overrun_nxt = 1'b0;
            end else if (r_irq) begin
                w_overrun_nxt = 1'b1;
            end
        end else if (irq_ack) begin
            w_irq_nxt     = 1'b0;
            w_overrun_nxt = 1'b0;
        end
    end

    // State, counter, configuration and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_period    <= '0;
            r_mode      <= 1'b0;
            r_tick_prev <= 1'b0;
            r_busy      <= 1'b0;
            r_expired   <= 1'b0;
            r_irq       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_period    <= w_period_nxt;
            r_mode      <= w_mode_nxt;
            r_tick_prev <= tick_in;
            r_busy      <= (w_state_nxt == ST_RUN);
            r_expired   <= w_expire;
            r_irq       <= w_irq_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign count   = r_count;
    assign busy    = r_busy;
    assign expired = r_expired;
    assign irq     = r_irq;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer.
module tb_tick_timer;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             tick_in;
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] period;
    logic             irq_ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expired;
    logic             irq;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    tick_timer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick_in (tick_in),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .period  (period),
        .irq_ack (irq_ack),
        .count   (count),
        .busy    (busy),
        .expired (expired),
        .irq     (irq),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle tick followed by a low cycle.
    task automatic pulse_tick();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        step();
    endtask

    task automatic do_start(input logic [WIDTH-1:0] p, input logic m);
        period = p;
        mode   = m;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic cleanup();
        stop = 1'b1;
        irq_ack = 1'b1;
        step();
        stop = 1'b0;
        irq_ack = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; tick_in = 0; start = 0; stop = 0; mode = 0; period = '0; irq_ack = 0;
        step(); step();
        checks++;
        if ({count, busy, expired, irq, overrun} !== {16'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: count=%0d busy=%b exp=%b irq=%b ovr=%b required all 0", count, busy, expired, irq, overrun);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_one_shot();
        do_start(16'd3, 1'b0);
        checks++;
        if (count !== 16'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_load: count=%0d busy=%b required 3 1", count, busy);
        end
        pulse_tick();
        checks++;
        if (count !== 16'd2) begin
            errors++;
            $display("FAIL oneshot_tick1: count=%0d required 2", count);
        end
        pulse_tick();
        checks++;
        if (count !== 16'd1 || expired !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_tick2: count=%0d exp=%b required 1 0", count, expired);
        end
        tick_in = 1'b1;
        step();
        checks++;
        if ({count, busy, expired, irq} !== {16'd0, 3'b011}) begin
            errors++;
            $display("FAIL oneshot_expire: count=%0d busy=%b exp=%b irq=%b required 0 0 1 1", count, busy, expired, irq);
        end
        tick_in = 1'b0;
        step();
        checks++;
        if (expired !== 1'b0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_pulse_end: exp=%b irq=%b required 0 1", expired, irq);
        end
        // Ticks in IDLE must not move the counter.
        pulse_tick();
        checks++;
        if (count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick: count=%0d busy=%b required 0 0", count, busy);
        end
        cleanup();
    endtask

    task automatic test_periodic_held();
        int n_exp;
        n_exp = 0;
        do_start(16'd2, 1'b1);
        period = 16'd7;  // live input change must not affect the latched period
        for (int r = 0; r < 4; r++) begin
            tick_in = 1'b1;
            for (int c = 0; c < 5; c++) begin
                step();
                if (expired) n_exp++;
            end
            tick_in = 1'b0;
            step();
            if (expired) n_exp++;
        end
        checks++;
        if (n_exp !== 2) begin
            errors++;
            $display("FAIL periodic_expiries: got=%0d required 2", n_exp);
        end
        checks++;
        if (count !== 16'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL periodic_reload: count=%0d busy=%b required 2 1", count, busy);
        end
        checks++;
        if (irq !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL periodic_flags: irq=%b ovr=%b required 1 1", irq, overrun);
        end
        cleanup();
    endtask

    task automatic test_overrun_ack();
        do_start(16'd1, 1'b1);
        pulse_tick();
        checks++;
        if (irq !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: irq=%b ovr=%b required 1 0", irq, overrun);
        end
        pulse_tick();
        checks++;
        if (irq !== 1'b1 || overrun !== 1'b1 || count !== 16'd1) begin
            errors++;
            $display("FAIL ovr_second: irq=%b ovr=%b count=%0d required 1 1 1", irq, overrun, count);
        end
        tick_in = 1'b1;
        irq_ack = 1'b1;
        step();
        checks++;
        if (irq !== 1'b1 || overrun !== 1'b0 || expired !== 1'b1) begin
            errors++;
            $display("FAIL ack_with_expiry: irq=%b ovr=%b exp=%b required 1 0 1", irq, overrun, expired);
        end
        tick_in = 1'b0;
        irq_ack = 1'b0;
        step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checks++;
        if (irq !== 1'b0 || overrun !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ack_alone: irq=%b ovr=%b busy=%b required 0 0 1", irq, overrun, busy);
        end
        cleanup();
    endtask

    task automatic test_collisions();
        do_start(16'd0, 1'b0);
        checks++;
        if (busy !== 1'b0 || count !== 16'd0) begin
            errors++;
            $display("FAIL start_zero: busy=%b count=%0d required 0 0", busy, count);
        end
        do_start(16'd4, 1'b0);
        period = 16'd5;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== 16'd0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL start_stop: busy=%b count=%0d exp=%b required 0 0 0", busy, count, expired);
        end
        do_start(16'd2, 1'b0);
        pulse_tick();
        tick_in = 1'b1;
        period = 16'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        tick_in = 1'b0;
        checks++;
        if (count !== 16'd6 || expired !== 1'b0 || busy !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL restart_on_last: count=%0d exp=%b busy=%b irq=%b required 6 0 1 0", count, expired, busy, irq);
        end
        step();
        // stop in IDLE is a no-op
        cleanup();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== 16'd0) begin
            errors++;
            $display("FAIL stop_idle: busy=%b count=%0d required 0 0", busy, count);
        end
    endtask

    task automatic test_async_reset();
        do_start(16'd1, 1'b1);
        pulse_tick();
        do_start(16'd7, 1'b0);
        pulse_tick();
        pulse_tick();
        checks++;
        if (count !== 16'd5 || irq !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: count=%0d irq=%b busy=%b required 5 1 1", count, irq, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({count, busy, expired, irq, overrun} !== {16'd0, 4'b0000}) begin
            errors++;
            $display("FAIL async_reset: count=%0d busy=%b exp=%b irq=%b ovr=%b required all 0", count, busy, expired, irq, overrun);
        end
        step();
        reset = 1'b1;
        pulse_tick();
        pulse_tick();
        checks++;
        if (busy !== 1'b0 || count !== 16'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ticks: busy=%b count=%0d irq=%b required 0 0 0", busy, count, irq);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic_held();
        test_overrun_ack();
        test_collisions();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
